// File: rtl/axis_dwidth_bridge_if.sv
// AXI-Stream bundle used on both sides of the width bridge.
// BYTES sets the tdata/tkeep width of one side.
interface axis_dwidth_bridge_if #(
  parameter int BYTES = 4
);
  logic [8*BYTES-1:0] tdata;
  logic [BYTES-1:0]   tkeep;
  logic               tlast;
  logic               tvalid;
  logic               tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_dwidth_bridge.sv
// AXI-Stream width converter: integer-ratio upsize, downsize,
// or a single register slice when both widths match.
module axis_dwidth_bridge #(
  parameter int S_BYTES = 4,
  parameter int M_BYTES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  axis_dwidth_bridge_if.slave  s_axis,
  axis_dwidth_bridge_if.master m_axis
);
  localparam int MAXB = (S_BYTES > M_BYTES) ? S_BYTES : M_BYTES;
  localparam int MINB = (S_BYTES > M_BYTES) ? M_BYTES : S_BYTES;
  localparam int MIND = (MINB < 1) ? 1 : MINB;
  localparam int R    = MAXB / MIND;
  localparam int IW   = (R > 1) ? $clog2(R) : 1;
  localparam logic [IW-1:0] LAST = IW'(R - 1);

  if (MINB < 1 || (MAXB % MIND) != 0) begin : g_bad
    $error("axis_dwidth_bridge: widths %0d/%0d not an integer ratio",
           S_BYTES, M_BYTES);
  end

  if (M_BYTES >= S_BYTES) begin : g_up
    localparam int SW = 8 * S_BYTES;

    logic [8*M_BYTES-1:0] data_q, data_d;
    logic [M_BYTES-1:0]   keep_q, keep_d;
    logic                 last_q, last_d;
    logic                 valid_q, valid_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 s_fire;

    assign s_axis.tready = !valid_q || m_axis.tready;
    assign s_fire = s_axis.tvalid && s_axis.tready;

    always_comb begin
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      valid_d = valid_q;
      idx_d   = idx_q;
      if (valid_q && m_axis.tready) begin
        valid_d = 1'b0;
      end
      if (s_fire) begin
        // a fresh beat starts clean so early tlast leaves empty lanes
        if (idx_q == '0) begin
          data_d = '0;
          keep_d = '0;
        end
        data_d[idx_q*SW +: SW]           = s_axis.tdata;
        keep_d[idx_q*S_BYTES +: S_BYTES] = s_axis.tkeep;
        if (idx_q == LAST || s_axis.tlast) begin
          valid_d = 1'b1;
          last_d  = s_axis.tlast;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_q  <= '0;
        keep_q  <= '0;
        last_q  <= 1'b0;
        valid_q <= 1'b0;
        idx_q   <= '0;
      end else begin
        data_q  <= data_d;
        keep_q  <= keep_d;
        last_q  <= last_d;
        valid_q <= valid_d;
        idx_q   <= idx_d;
      end
    end

    assign m_axis.tdata  = data_q;
    assign m_axis.tkeep  = keep_q;
    assign m_axis.tlast  = last_q;
    assign m_axis.tvalid = valid_q;
  end else begin : g_dn
    localparam int MW = 8 * M_BYTES;

    logic [8*S_BYTES-1:0] hdata_q, hdata_d;
    logic [S_BYTES-1:0]   hkeep_q, hkeep_d;
    logic                 hlast_q, hlast_d;
    logic                 held_q, held_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        top;
    logic                 at_top;
    logic                 s_fire;

    // highest lane carrying any byte; trailing empty lanes are skipped
    always_comb begin
      top = '0;
      for (int i = 0; i < R; i++) begin
        if (|hkeep_q[i*M_BYTES +: M_BYTES]) top = IW'(i);
      end
    end

    assign at_top = (idx_q == top);
    assign s_axis.tready = !held_q || (m_axis.tready && at_top);
    assign s_fire = s_axis.tvalid && s_axis.tready;

    always_comb begin
      hdata_d = hdata_q;
      hkeep_d = hkeep_q;
      hlast_d = hlast_q;
      held_d  = held_q;
      idx_d   = idx_q;
      if (held_q && m_axis.tready) begin
        if (at_top) begin
          held_d = 1'b0;
          idx_d  = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      if (s_fire) begin
        hdata_d = s_axis.tdata;
        hkeep_d = s_axis.tkeep;
        hlast_d = s_axis.tlast;
        held_d  = 1'b1;
        idx_d   = '0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hdata_q <= '0;
        hkeep_q <= '0;
        hlast_q <= 1'b0;
        held_q  <= 1'b0;
        idx_q   <= '0;
      end else begin
        hdata_q <= hdata_d;
        hkeep_q <= hkeep_d;
        hlast_q <= hlast_d;
        held_q  <= held_d;
        idx_q   <= idx_d;
      end
    end

    assign m_axis.tdata  = hdata_q[idx_q*MW +: MW];
    assign m_axis.tkeep  = hkeep_q[idx_q*M_BYTES +: M_BYTES];
    assign m_axis.tlast  = hlast_q && at_top;
    assign m_axis.tvalid = held_q;
  end
endmodule

// File: tb/tb_axis_dwidth_bridge.sv
// Scoreboard bench: 4->8 upsize, 8->4 downsize and 4->4 slice
// instances sharing one clock and reset.
module tb_axis_dwidth_bridge;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int up_cnt = 0;
  int dn_cnt = 0;
  int eq_cnt = 0;
  bit rnd_on = 1'b0;
  bit stall  = 1'b0;

  beat_t up_q[$];
  beat_t dn_q[$];
  beat_t eq_q[$];

  logic [63:0] acc_d;
  logic [7:0]  acc_k;
  int          acc_n = 0;

  axis_dwidth_bridge_if #(.BYTES(4)) su ();
  axis_dwidth_bridge_if #(.BYTES(8)) mu ();
  axis_dwidth_bridge_if #(.BYTES(8)) sd ();
  axis_dwidth_bridge_if #(.BYTES(4)) md ();
  axis_dwidth_bridge_if #(.BYTES(4)) se ();
  axis_dwidth_bridge_if #(.BYTES(4)) me ();

  axis_dwidth_bridge #(.S_BYTES(4), .M_BYTES(8)) u_up (
    .clk(clk), .reset(rst), .s_axis(su), .m_axis(mu));
  axis_dwidth_bridge #(.S_BYTES(8), .M_BYTES(4)) u_dn (
    .clk(clk), .reset(rst), .s_axis(sd), .m_axis(md));
  axis_dwidth_bridge #(.S_BYTES(4), .M_BYTES(4)) u_eq (
    .clk(clk), .reset(rst), .s_axis(se), .m_axis(me));

  function automatic beat_t mk(input logic [63:0] d,
                               input logic [7:0] k,
                               input logic l);
    mk = {d, k, l};
  endfunction

  task automatic up_expect(input logic [31:0] d,
                           input logic [3:0] k, input logic l);
    if (acc_n == 0) begin
      acc_d = '0;
      acc_k = '0;
    end
    acc_d[acc_n*32 +: 32] = d;
    acc_k[acc_n*4 +: 4]   = k;
    acc_n++;
    if (acc_n == 2 || l) begin
      up_q.push_back(mk(acc_d, acc_k, l));
      acc_n = 0;
    end
  endtask

  task automatic dn_expect(input logic [63:0] d,
                           input logic [7:0] k, input logic l);
    int top = 0;
    for (int i = 0; i < 2; i++) if (|k[i*4 +: 4]) top = i;
    for (int i = 0; i <= top; i++)
      dn_q.push_back(mk(64'(d[i*32 +: 32]), 8'(k[i*4 +: 4]),
                        l && (i == top)));
  endtask

  task automatic ready_gen();
    forever begin
      mu.tready = stall ? 1'b0 : rnd_on ? 1'($urandom_range(0, 1)) : 1'b1;
      md.tready = stall ? 1'b0 : rnd_on ? 1'($urandom_range(0, 1)) : 1'b1;
      me.tready = stall ? 1'b0 : rnd_on ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic mon_up();
    beat_t e, p;
    bit pv = 0, pr = 0;
    p = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
      end else begin
        if (pv && !pr) begin
          checks++;
          if (mu.tvalid !== 1'b1 || {mu.tdata, mu.tkeep, mu.tlast} !== p) begin
            fails++;
            $display("FAIL up_stable: got v=%b %h/%h/%b want %h/%h/%b",
                     mu.tvalid, mu.tdata, mu.tkeep, mu.tlast, p.d, p.k, p.l);
          end
        end
        if (mu.tvalid && mu.tready) begin
          up_cnt++;
          checks++;
          if (up_q.size() == 0) begin
            fails++;
            $display("FAIL up_beat: got %h/%h/%b want none",
                     mu.tdata, mu.tkeep, mu.tlast);
          end else begin
            e = up_q.pop_front();
            if ({mu.tdata, mu.tkeep, mu.tlast} !== e) begin
              fails++;
              $display("FAIL up_beat: got %h/%h/%b want %h/%h/%b",
                       mu.tdata, mu.tkeep, mu.tlast, e.d, e.k, e.l);
            end
          end
        end
        pv = mu.tvalid;
        pr = mu.tready;
        p  = {mu.tdata, mu.tkeep, mu.tlast};
      end
    end
  endtask

  task automatic mon_dn();
    beat_t e;
    logic [36:0] p = '0;
    bit pv = 0, pr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
      end else begin
        if (pv && !pr) begin
          checks++;
          if (md.tvalid !== 1'b1 || {md.tdata, md.tkeep, md.tlast} !== p) begin
            fails++;
            $display("FAIL dn_stable: got v=%b %h/%h/%b want %h",
                     md.tvalid, md.tdata, md.tkeep, md.tlast, p);
          end
        end
        if (md.tvalid && md.tready) begin
          dn_cnt++;
          checks++;
          if (dn_q.size() == 0) begin
            fails++;
            $display("FAIL dn_beat: got %h/%h/%b want none",
                     md.tdata, md.tkeep, md.tlast);
          end else begin
            e = dn_q.pop_front();
            if ({md.tdata, md.tkeep, md.tlast} !== {e.d[31:0], e.k[3:0], e.l}) begin
              fails++;
              $display("FAIL dn_beat: got %h/%h/%b want %h/%h/%b",
                       md.tdata, md.tkeep, md.tlast, e.d[31:0], e.k[3:0], e.l);
            end
          end
        end
        pv = md.tvalid;
        pr = md.tready;
        p  = {md.tdata, md.tkeep, md.tlast};
      end
    end
  endtask

  task automatic mon_eq();
    beat_t e;
    logic [36:0] p = '0;
    bit pv = 0, pr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
      end else begin
        if (pv && !pr) begin
          checks++;
          if (me.tvalid !== 1'b1 || {me.tdata, me.tkeep, me.tlast} !== p) begin
            fails++;
            $display("FAIL eq_stable: got v=%b %h/%h/%b want %h",
                     me.tvalid, me.tdata, me.tkeep, me.tlast, p);
          end
        end
        if (me.tvalid && me.tready) begin
          eq_cnt++;
          checks++;
          if (eq_q.size() == 0) begin
            fails++;
            $display("FAIL eq_beat: got %h/%h/%b want none",
                     me.tdata, me.tkeep, me.tlast);
          end else begin
            e = eq_q.pop_front();
            if ({me.tdata, me.tkeep, me.tlast} !== {e.d[31:0], e.k[3:0], e.l}) begin
              fails++;
              $display("FAIL eq_beat: got %h/%h/%b want %h/%h/%b",
                       me.tdata, me.tkeep, me.tlast, e.d[31:0], e.k[3:0], e.l);
            end
          end
        end
        pv = me.tvalid;
        pr = me.tready;
        p  = {me.tdata, me.tkeep, me.tlast};
      end
    end
  endtask

  task automatic up_send(input logic [31:0] d, input logic [3:0] k,
                         input logic l, output int w);
    su.tdata = d; su.tkeep = k; su.tlast = l; su.tvalid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!su.tready && w < 500) begin
      w++;
      @(negedge clk);
    end
    if (w >= 500) begin
      checks++; fails++;
      $display("FAIL up_send_timeout: got no tready want tready");
    end
    @(posedge clk);
    #1 su.tvalid = 1'b0;
  endtask

  task automatic dn_send(input logic [63:0] d, input logic [7:0] k,
                         input logic l, output int w);
    sd.tdata = d; sd.tkeep = k; sd.tlast = l; sd.tvalid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!sd.tready && w < 500) begin
      w++;
      @(negedge clk);
    end
    if (w >= 500) begin
      checks++; fails++;
      $display("FAIL dn_send_timeout: got no tready want tready");
    end
    @(posedge clk);
    #1 sd.tvalid = 1'b0;
  endtask

  task automatic eq_send(input logic [31:0] d, input logic [3:0] k,
                         input logic l, output int w);
    se.tdata = d; se.tkeep = k; se.tlast = l; se.tvalid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!se.tready && w < 500) begin
      w++;
      @(negedge clk);
    end
    if (w >= 500) begin
      checks++; fails++;
      $display("FAIL eq_send_timeout: got no tready want tready");
    end
    @(posedge clk);
    #1 se.tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((up_q.size() + dn_q.size() + eq_q.size()) != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ((up_q.size() + dn_q.size() + eq_q.size()) != 0) begin
      fails++;
      $display("FAIL %s_drain: got pending up=%0d dn=%0d eq=%0d want 0",
               tag, up_q.size(), dn_q.size(), eq_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mu.tvalid, mu.tlast, mu.tkeep, mu.tdata} !== 74'd0) begin
      fails++;
      $display("FAIL up_reset_out: got v=%b l=%b k=%h d=%h want 0",
               mu.tvalid, mu.tlast, mu.tkeep, mu.tdata);
    end
    checks++;
    if ({md.tvalid, md.tlast, md.tkeep, md.tdata} !== 38'd0) begin
      fails++;
      $display("FAIL dn_reset_out: got v=%b l=%b k=%h d=%h want 0",
               md.tvalid, md.tlast, md.tkeep, md.tdata);
    end
    checks++;
    if ({me.tvalid, me.tlast, me.tkeep, me.tdata} !== 38'd0) begin
      fails++;
      $display("FAIL eq_reset_out: got v=%b l=%b k=%h d=%h want 0",
               me.tvalid, me.tlast, me.tkeep, me.tdata);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({su.tready, sd.tready, se.tready} !== 3'b111) begin
      fails++;
      $display("FAIL reset_tready: got %b want 111",
               {su.tready, sd.tready, se.tready});
    end
  endtask

  task automatic test_up_pair();
    int w;
    up_q.push_back(mk(64'h2222222211111111, 8'hFF, 1'b1));
    up_send(32'h11111111, 4'hF, 1'b0, w);
    up_send(32'h22222222, 4'hF, 1'b1, w);
    checks++;
    if (mu.tvalid !== 1'b1) begin
      fails++;
      $display("FAIL up_latency: got tvalid=%b want 1", mu.tvalid);
    end
    wait_drain("up_pair");
  endtask

  task automatic test_up_short();
    int w;
    up_q.push_back(mk(64'hB0B1B2B3A0A1A2A3, 8'hFF, 1'b0));
    up_q.push_back(mk(64'h00000000C0C1C2C3, 8'h0F, 1'b1));
    up_send(32'hA0A1A2A3, 4'hF, 1'b0, w);
    up_send(32'hB0B1B2B3, 4'hF, 1'b0, w);
    up_send(32'hC0C1C2C3, 4'hF, 1'b1, w);
    wait_drain("up_short");
  endtask

  task automatic test_up_stream();
    int w, tot = 0, c0 = up_cnt;
    logic [31:0] d;
    for (int i = 0; i < 64; i++) begin
      d = 32'(i) * 32'h01010101 + 32'h00C0FFEE;
      up_expect(d, 4'hF, i == 63);
      up_send(d, 4'hF, i == 63, w);
      tot += w;
    end
    wait_drain("up_stream");
    checks++;
    if (tot != 0) begin
      fails++;
      $display("FAIL up_stream_stall: got %0d stall cycles want 0", tot);
    end
    checks++;
    if (up_cnt - c0 != 32) begin
      fails++;
      $display("FAIL up_stream_count: got %0d beats want 32", up_cnt - c0);
    end
  endtask

  task automatic test_up_random();
    int w, len;
    logic [31:0] d;
    logic [3:0]  k;
    rnd_on = 1'b1;
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        d = $urandom;
        k = (b == len - 1) ? 4'($urandom_range(1, 15)) : 4'hF;
        up_expect(d, k, b == len - 1);
        up_send(d, k, b == len - 1, w);
      end
    end
    rnd_on = 1'b0;
    wait_drain("up_random");
  endtask

  task automatic test_dn_partial();
    int w, c0 = dn_cnt;
    dn_q.push_back(mk(64'hAAAAAAAA, 8'hF, 1'b1));
    dn_send(64'hBBBBBBBBAAAAAAAA, 8'h0F, 1'b1, w);
    checks++;
    if (md.tvalid !== 1'b1) begin
      fails++;
      $display("FAIL dn_latency: got tvalid=%b want 1", md.tvalid);
    end
    wait_drain("dn_partial");
    checks++;
    if (dn_cnt - c0 != 1) begin
      fails++;
      $display("FAIL dn_skip_lane: got %0d beats want 1", dn_cnt - c0);
    end
    dn_expect(64'h1234567887654321, 8'h00, 1'b1);
    dn_send(64'h1234567887654321, 8'h00, 1'b1, w);
    dn_expect(64'hDEADBEEF0BADF00D, 8'hF0, 1'b0);
    dn_send(64'hDEADBEEF0BADF00D, 8'hF0, 1'b0, w);
    dn_expect(64'h0000000155555555, 8'h5A, 1'b1);
    dn_send(64'h0000000155555555, 8'h5A, 1'b1, w);
    wait_drain("dn_sparse");
  endtask

  task automatic test_dn_rate();
    int w, tot = 0;
    logic [63:0] d;
    for (int i = 0; i < 10; i++) begin
      d = {$urandom, $urandom};
      dn_expect(d, 8'hFF, i == 9);
      dn_send(d, 8'hFF, i == 9, w);
      tot += w;
    end
    wait_drain("dn_rate");
    checks++;
    if (tot != 9) begin
      fails++;
      $display("FAIL dn_rate: got %0d wait cycles want 9", tot);
    end
  endtask

  task automatic test_dn_random();
    int w, len;
    logic [63:0] d;
    rnd_on = 1'b1;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        d = {$urandom, $urandom};
        dn_expect(d, 8'hFF, b == len - 1);
        dn_send(d, 8'hFF, b == len - 1, w);
      end
    end
    rnd_on = 1'b0;
    wait_drain("dn_random");
  endtask

  task automatic test_eq();
    int w, tot = 0;
    logic [31:0] d;
    logic [3:0]  k;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      k = 4'($urandom_range(0, 15));
      eq_q.push_back(mk(64'(d), 8'(k), i == 7));
      eq_send(d, k, i == 7, w);
      tot += w;
      checks++;
      if (me.tvalid !== 1'b1) begin
        fails++;
        $display("FAIL eq_latency: got tvalid=%b want 1", me.tvalid);
      end
    end
    checks++;
    if (tot != 0) begin
      fails++;
      $display("FAIL eq_rate: got %0d wait cycles want 0", tot);
    end
    rnd_on = 1'b1;
    for (int i = 0; i < 30; i++) begin
      d = $urandom;
      eq_q.push_back(mk(64'(d), 8'hF, i % 5 == 4));
      eq_send(d, 4'hF, i % 5 == 4, w);
    end
    rnd_on = 1'b0;
    wait_drain("eq");
  endtask

  task automatic test_reset_mid();
    int w;
    stall = 1'b1;
    dn_send(64'hCCCCCCCCDDDDDDDD, 8'hFF, 1'b1, w);
    up_send(32'h33333333, 4'hF, 1'b0, w);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mu.tvalid, md.tvalid} !== 2'b00) begin
      fails++;
      $display("FAIL reset_async: got up=%b dn=%b want 0 0",
               mu.tvalid, md.tvalid);
    end
    acc_n = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    stall = 1'b0;
    up_q.push_back(mk(64'h5555555544444444, 8'hFF, 1'b1));
    up_send(32'h44444444, 4'hF, 1'b0, w);
    up_send(32'h55555555, 4'hF, 1'b1, w);
    dn_expect(64'h7777777766666666, 8'hFF, 1'b1);
    dn_send(64'h7777777766666666, 8'hFF, 1'b1, w);
    wait_drain("reset_mid");
  endtask

  initial begin
    su.tvalid = 1'b0; su.tdata = '0; su.tkeep = '0; su.tlast = 1'b0;
    sd.tvalid = 1'b0; sd.tdata = '0; sd.tkeep = '0; sd.tlast = 1'b0;
    se.tvalid = 1'b0; se.tdata = '0; se.tkeep = '0; se.tlast = 1'b0;
    fork
      ready_gen();
      mon_up();
      mon_dn();
      mon_eq();
    join_none
    test_reset();
    test_up_pair();
    test_up_short();
    test_up_stream();
    test_up_random();
    test_dn_partial();
    test_dn_rate();
    test_dn_random();
    test_eq();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
